// File: rtl/wb_cfg_master_pkg.sv
// Shared bus widths, FSM state type and command record for the Wishbone
// configuration master and its command FIFO.
package wb_cfg_master_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } state_e;

  // 1 + 4 + 32 + 32 = 69 bits
  typedef struct packed {
    logic                we;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
  } cmd_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO; full/empty are decoded from the registered
// occupancy count so they carry no path from the pop side.
module wb_cmd_fifo
  import wb_cfg_master_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  cmd_t data_i,
  input  logic pop_i,
  output cmd_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s, pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/wb_cfg_master.sv
// Wishbone classic initiator fed by a valid/ready command stream, one response
// per command. Define WB_TIMEOUT_EN to build the ack-timeout counter.
module wb_cfg_master
  import wb_cfg_master_pkg::*;
#(
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  input  logic                wbm_ack_i
);

  state_e              state_q, state_d;
  cmd_t                cmd_s, head_s;
  logic                fifo_full_s, fifo_empty_s, pop_s;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
`ifdef WB_TIMEOUT_EN
  logic                rsp_err_q, rsp_err_d;
  logic [15:0]         to_cnt_q, to_cnt_d;
  logic                timeout_s;

  assign timeout_s = (to_cnt_q == 16'(TIMEOUT_CYCLES));
`endif

  assign cmd_s = '{we: cmd_we_i, sel: cmd_sel_i, adr: cmd_adr_i, dat: cmd_dat_i};

  wb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .push_i  (cmd_valid_i),
    .data_i  (cmd_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign cmd_ready_o = ~fifo_full_s;

  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
`ifdef WB_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          cyc_d   = 1'b1;
          we_d    = head_s.we;
          sel_d   = head_s.sel;
          adr_d   = head_s.adr;
          dat_d   = head_s.dat;
`ifdef WB_TIMEOUT_EN
          to_cnt_d = 16'd0;
`endif
          state_d = BUS;
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout expiring on the same edge.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? {WB_DAT_W{1'b0}} : wbm_dat_i;
`ifdef WB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = RSP;
        end
`ifdef WB_TIMEOUT_EN
        else if (timeout_s) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = {WB_DAT_W{1'b0}};
          rsp_err_d   = 1'b1;
          state_d     = RSP;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
          state_d  = BUS;
        end
`else
        else begin
          state_d = BUS;
        end
`endif
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RSP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= {WB_SEL_W{1'b0}};
      adr_q       <= {WB_ADR_W{1'b0}};
      dat_q       <= {WB_DAT_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= {WB_DAT_W{1'b0}};
`ifdef WB_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
      to_cnt_q    <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
`ifdef WB_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
`ifdef WB_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule
